// File: rtl/uidbufr_interconnect.sv
// Four-client round-robin arbiter for the shared FDMA read channel: grants whole
// bursts, forwards the winner's address/size, and steers read data back to it.
module uidbufr_interconnect #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21
) (
  input  logic                      ui_clk,
  input  logic                      ui_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
  input  logic                      fdma_rareq_1,
  input  logic [15:0]               fdma_rsize_1,
  output logic                      fdma_rbusy_1,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
  output logic                      fdma_rvalid_1,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
  input  logic                      fdma_rareq_2,
  input  logic [15:0]               fdma_rsize_2,
  output logic                      fdma_rbusy_2,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
  output logic                      fdma_rvalid_2,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
  input  logic                      fdma_rareq_3,
  input  logic [15:0]               fdma_rsize_3,
  output logic                      fdma_rbusy_3,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
  output logic                      fdma_rvalid_3,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
  input  logic                      fdma_rareq_4,
  input  logic [15:0]               fdma_rsize_4,
  output logic                      fdma_rbusy_4,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
  output logic                      fdma_rvalid_4,
  output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
  output logic                      fdma_rareq,
  output logic [15:0]               fdma_rsize,
  input  logic                      fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
  input  logic                      fdma_rvalid
);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sel_q, sel_d;
  logic [1:0]                last_q, last_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [15:0]               rsize_q, rsize_d;
  logic                      rareq_q, rareq_d;
  logic [3:0]                busy_q, busy_d;

  logic [3:0]                req;
  logic [AXI_ADDR_WIDTH-1:0] addr_arr [4];
  logic [15:0]               size_arr [4];
  logic                      found;
  logic [1:0]                win;
  logic [1:0]                cand;

  assign req         = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};
  assign addr_arr[0] = fdma_raddr_1;
  assign addr_arr[1] = fdma_raddr_2;
  assign addr_arr[2] = fdma_raddr_3;
  assign addr_arr[3] = fdma_raddr_4;
  assign size_arr[0] = fdma_rsize_1;
  assign size_arr[1] = fdma_rsize_2;
  assign size_arr[2] = fdma_rsize_3;
  assign size_arr[3] = fdma_rsize_4;

  // Scan starts just after the last winner; the last winner itself is checked last.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    raddr_d = raddr_q;
    rsize_d = rsize_q;
    rareq_d = rareq_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = REQ;
          sel_d   = win;
          last_d  = win;
          raddr_d = addr_arr[win];
          rsize_d = size_arr[win];
          rareq_d = 1'b1;
          busy_d  = 4'b0001 << win;
        end
      end
      REQ: begin
        if (fdma_rbusy) begin
          state_d = DATA;
          rareq_d = 1'b0;
        end
      end
      DATA: begin
        if (!fdma_rbusy) begin
          state_d = IDLE;
          busy_d  = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        rareq_d = 1'b0;
        busy_d  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      raddr_q <= '0;
      rsize_q <= '0;
      rareq_q <= 1'b0;
      busy_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      raddr_q <= raddr_d;
      rsize_q <= rsize_d;
      rareq_q <= rareq_d;
      busy_q  <= busy_d;
    end
  end

  assign fdma_raddr   = raddr_q;
  assign fdma_rsize   = rsize_q;
  assign fdma_rareq   = rareq_q;
  assign fdma_rbusy_1 = busy_q[0];
  assign fdma_rbusy_2 = busy_q[1];
  assign fdma_rbusy_3 = busy_q[2];
  assign fdma_rbusy_4 = busy_q[3];

  // Return path follows the registered selection in every state, with no added latency.
  assign fdma_rvalid_1 = (sel_q == 2'd0) && fdma_rvalid;
  assign fdma_rvalid_2 = (sel_q == 2'd1) && fdma_rvalid;
  assign fdma_rvalid_3 = (sel_q == 2'd2) && fdma_rvalid;
  assign fdma_rvalid_4 = (sel_q == 2'd3) && fdma_rvalid;
  assign fdma_rdata_1  = (sel_q == 2'd0) ? fdma_rdata : '0;
  assign fdma_rdata_2  = (sel_q == 2'd1) ? fdma_rdata : '0;
  assign fdma_rdata_3  = (sel_q == 2'd2) ? fdma_rdata : '0;
  assign fdma_rdata_4  = (sel_q == 2'd3) ? fdma_rdata : '0;
endmodule

// File: tb/tb_uidbufr_interconnect.sv
// Bench for uidbufr_interconnect: four client drivers, a simple FDMA controller
// model, and a scoreboard of read beats keyed by the expected grant order.
module tb_uidbufr_interconnect;
  logic        ui_clk;
  logic        ui_rst;
  logic [3:0]  crq;
  logic [20:0] caddr [4];
  logic [15:0] csize [4];
  logic [3:0]  kbusy, kvalid;
  logic [31:0] kdata [4];
  logic [20:0] fdma_raddr;
  logic        fdma_rareq;
  logic [15:0] fdma_rsize;
  logic        c_busy, c_valid;
  logic [31:0] c_data;

  typedef struct { int ch; logic [20:0] addr; logic [15:0] size; } burst_t;
  typedef struct { int ch; logic [31:0] data; } beat_t;

  burst_t exp_q [$];
  beat_t  sb [$];
  burst_t cur;
  burst_t vec [5];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int beats    = 0;
  int rise_cyc = 0;
  int fb_fall  = 0;
  int last_fall = -1;
  logic prev_rareq = 1'b0, prev_fbusy = 1'b0;
  logic [3:0] prev_kbusy = 4'b0;

  int   c_st = 0;
  int   c_cnt = 0;
  int   c_left = 0;
  int   c_lat = 2;
  logic c_fixed = 1'b0;

  uidbufr_interconnect #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(21)) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .fdma_raddr_1(caddr[0]), .fdma_rareq_1(crq[0]), .fdma_rsize_1(csize[0]),
    .fdma_rbusy_1(kbusy[0]), .fdma_rdata_1(kdata[0]), .fdma_rvalid_1(kvalid[0]),
    .fdma_raddr_2(caddr[1]), .fdma_rareq_2(crq[1]), .fdma_rsize_2(csize[1]),
    .fdma_rbusy_2(kbusy[1]), .fdma_rdata_2(kdata[1]), .fdma_rvalid_2(kvalid[1]),
    .fdma_raddr_3(caddr[2]), .fdma_rareq_3(crq[2]), .fdma_rsize_3(csize[2]),
    .fdma_rbusy_3(kbusy[2]), .fdma_rdata_3(kdata[2]), .fdma_rvalid_3(kvalid[2]),
    .fdma_raddr_4(caddr[3]), .fdma_rareq_4(crq[3]), .fdma_rsize_4(csize[3]),
    .fdma_rbusy_4(kbusy[3]), .fdma_rdata_4(kdata[3]), .fdma_rvalid_4(kvalid[3]),
    .fdma_raddr(fdma_raddr), .fdma_rareq(fdma_rareq), .fdma_rsize(fdma_rsize),
    .fdma_rbusy(c_busy), .fdma_rdata(c_data), .fdma_rvalid(c_valid)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  // Controller model: busy rises c_lat+1 cycles after a request, then size beats, then busy drops.
  always @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      c_st <= 0; c_cnt <= 0; c_left <= 0;
      c_busy <= 1'b0; c_valid <= 1'b0; c_data <= '0;
    end else begin
      case (c_st)
        0: if (fdma_rareq) begin c_st <= 1; c_cnt <= c_lat; c_left <= int'(fdma_rsize); end
        1: if (c_cnt == 0) begin c_busy <= 1'b1; c_st <= 2; end
           else c_cnt <= c_cnt - 1;
        default: begin
          if (c_left == 0) begin
            c_valid <= 1'b0; c_busy <= 1'b0; c_st <= 0;
          end else begin
            c_valid <= 1'b1;
            c_data  <= c_fixed ? 32'hA5A5_A5A5 : $urandom();
            c_left  <= c_left - 1;
          end
        end
      endcase
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  task automatic monitor();
    if (fdma_rareq === 1'b1 && !prev_rareq) begin
      if (exp_q.size() == 0) fail("unexpected_grant");
      else begin
        cur = exp_q.pop_front();
        chk("grant_onehot", 64'(kbusy), 64'(4'b0001 << (cur.ch - 1)));
        chk("grant_addr", 64'(fdma_raddr), 64'(cur.addr));
        chk("grant_size", 64'(fdma_rsize), 64'(cur.size));
        if (last_fall >= 0) chk("idle_gap_ok", 64'(cyc - last_fall >= 1), 64'd1);
        beats = 0;
      end
    end
    if (c_busy && !prev_fbusy) rise_cyc = cyc;
    if (!fdma_rareq && prev_rareq) chk("rareq_release_cyc", 64'(cyc), 64'(rise_cyc + 1));
    if (!c_busy && prev_fbusy) fb_fall = cyc;
    if (kbusy == 4'b0 && prev_kbusy != 4'b0) begin
      chk("rbusy_k_fall_cyc", 64'(cyc), 64'(fb_fall + 1));
      chk("burst_beats", 64'(beats), 64'(cur.size));
      last_fall = cyc;
    end
    if (c_valid) sb.push_back('{cur.ch, c_data});
    for (int k = 0; k < 4; k++) begin
      if (kvalid[k]) begin
        if (sb.size() == 0) fail("spurious_rvalid");
        else begin
          beat_t b = sb.pop_front();
          chk("beat_channel", 64'(k + 1), 64'(b.ch));
          chk("beat_data", 64'(kdata[k]), 64'(b.data));
          beats++;
        end
      end
    end
    if (c_valid) begin
      logic bad = 1'b0;
      for (int k = 0; k < 4; k++)
        if (k + 1 != cur.ch && (kvalid[k] !== 1'b0 || kdata[k] !== 32'h0)) bad = 1'b1;
      chk("isolation", 64'(bad), 64'd0);
    end
    prev_rareq = fdma_rareq;
    prev_fbusy = c_busy;
    prev_kbusy = kbusy;
    for (int k = 0; k < 4; k++) if (kbusy[k]) crq[k] = 1'b0;
  endtask

  task automatic tick();
    @(negedge ui_clk);
    cyc++;
    monitor();
  endtask

  task automatic issue(burst_t b);
    caddr[b.ch - 1] = b.addr;
    csize[b.ch - 1] = b.size;
    crq[b.ch - 1]   = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic run_until_done(int maxc);
    int n = 0;
    tick();
    while ((exp_q.size() != 0 || kbusy != 4'b0 || c_st != 0 || fdma_rareq) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) fail("burst_timeout");
  endtask

  task automatic check_reset_outputs(string tag);
    logic [3:0] v = 4'b0;
    for (int k = 0; k < 4; k++) v[k] = (kdata[k] != 32'h0);
    chk({tag, "_rareq"}, 64'(fdma_rareq), 64'd0);
    chk({tag, "_raddr"}, 64'(fdma_raddr), 64'd0);
    chk({tag, "_rsize"}, 64'(fdma_rsize), 64'd0);
    chk({tag, "_rbusy_k"}, 64'(kbusy), 64'd0);
    chk({tag, "_rvalid_k"}, 64'(kvalid), 64'd0);
    chk({tag, "_rdata_k_nonzero"}, 64'(v), 64'd0);
  endtask

  task automatic do_reset();
    ui_rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    sb.delete();
    exp_q.delete();
    cur.ch = 1;
    beats = 0;
    last_fall = -1;
    prev_rareq = 1'b0;
    prev_kbusy = 4'b0;
    crq = 4'b0;
    tick();
    tick();
    ui_rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int bad;
    vec[0] = '{2, 21'h1F_FFFF, 16'd1};
    vec[1] = '{3, 21'h00_0000, 16'd0};
    vec[2] = '{4, 21'h01_2345, 16'd5};
    vec[3] = '{1, 21'h00_ABCD, 16'd3};
    vec[4] = '{3, 21'h15_5555, 16'd17};
    crq = 4'b0;
    for (int k = 0; k < 4; k++) begin caddr[k] = '0; csize[k] = '0; end
    cur = '{1, 21'h0, 16'h0};

    @(negedge ui_clk);
    do_reset();

    // Single client with hand-checked grant latency.
    issue('{1, 21'h00400, 16'd256});
    tick();
    chk("grant_latency_rareq", 64'(fdma_rareq), 64'd1);
    chk("grant_latency_rbusy1", 64'(kbusy), 64'h1);
    run_until_done(2000);

    // Table of isolated bursts, boundary address and zero-length included.
    for (int i = 0; i < 5; i++) begin
      issue(vec[i]);
      run_until_done(500);
    end

    // All four together after reset, fixed data pattern for isolation.
    do_reset();
    c_fixed = 1'b1;
    issue('{1, 21'h01000, 16'd128});
    issue('{2, 21'h02000, 16'd256});
    issue('{3, 21'h03000, 16'd64});
    issue('{4, 21'h04000, 16'd32});
    run_until_done(3000);
    c_fixed = 1'b0;

    // Rotation: ch3 served, then ch1 and ch4 pending -> ch4 before ch1.
    issue('{3, 21'h00300, 16'd8});
    n = 0;
    while (kbusy[2] !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) fail("rotation_ch3_grant_timeout");
    issue('{4, 21'h00444, 16'd4});
    issue('{1, 21'h00111, 16'd6});
    run_until_done(500);

    // Reset at beat 100 of a 256-beat burst on ch3.
    issue('{3, 21'h03300, 16'd256});
    n = 0;
    while (beats < 100 && n < 1000) begin tick(); n++; end
    if (n >= 1000) fail("midburst_beat_timeout");
    do_reset();
    issue('{1, 21'h00AA0, 16'd4});
    issue('{4, 21'h00BB0, 16'd4});
    run_until_done(500);

    // Quiet channel.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fdma_rareq !== 1'b0 || kbusy !== 4'b0) bad++;
    end
    chk("idle_quiet_violations", 64'(bad), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("grants_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
